// File: rtl/nco_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nco_sweep_ctrl
// Purpose  : Frequency-sweep sequencer for the NCO core. Steps the NCO phase
//            increment through single-ramp, sawtooth or triangle chirps with a
//            programmable dwell per step, drains the NCO pipeline when the
//            sweep ends, and emits a step marker delayed to line up with the
//            NCO output samples.
// Ports    : clk, reset_n      - clock, asynchronous active-low reset
//            start, abort      - sweep start / early stop pulses
//            mode              - 0 ramp, 1 sawtooth, 2 triangle, 3 as 0
//            f_start/f_stop/f_step - sweep bounds and step (unsigned)
//            dwell             - cycles per frequency (0 behaves as 1)
//            phi_inc_o, nco_clken - to NCO phi_inc_i / clken
//            busy, done        - sweep status
//            step_o, step_aligned - new-frequency marker, raw and NCO-aligned
// Revision : 1.0 - initial release
// ============================================================================
module nco_sweep_ctrl #(
  parameter int APR     = 32,
  parameter int DWW     = 16,
  parameter int NCO_LAT = 7
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           abort,
  input  logic [1:0]     mode,
  input  logic [APR-1:0] f_start,
  input  logic [APR-1:0] f_stop,
  input  logic [APR-1:0] f_step,
  input  logic [DWW-1:0] dwell,
  output logic [APR-1:0] phi_inc_o,
  output logic           nco_clken,
  output logic           busy,
  output logic           done,
  output logic           step_o,
  output logic           step_aligned
);

  localparam int DRW = (NCO_LAT > 1) ? $clog2(NCO_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [APR-1:0]   phi_q, phi_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;          // 1 = moving down (triangle only)
  logic [DWW-1:0]   dcnt_q, dcnt_d;        // remaining dwell cycles
  logic [DWW-1:0]   dlen_q, dlen_d;        // dwell reload value, max(dwell,1)-1
  logic [1:0]       mode_q, mode_d;
  logic [APR-1:0]   fstart_q, fstart_d;
  logic [APR-1:0]   fstop_q, fstop_d;
  logic [APR-1:0]   fstep_q, fstep_d;
  logic [DRW-1:0]   drain_q, drain_d;
  logic [NCO_LAT-1:0] sr_q, sr_d;
  logic [NCO_LAT-1:0] sr_shift;

  // One extra bit so that a sum past the top of the range, or a borrow,
  // is visible instead of silently wrapping.
  logic [APR:0] cur_x, sum_x, diff_x, start_x, stop_x;
  logic         over, under;

  assign cur_x   = {1'b0, phi_q};
  assign start_x = {1'b0, fstart_q};
  assign stop_x  = {1'b0, fstop_q};
  assign sum_x   = cur_x + {1'b0, fstep_q};
  assign diff_x  = cur_x - {1'b0, fstep_q};
  assign over    = (sum_x > stop_x);
  assign under   = diff_x[APR] | (diff_x < start_x);

  logic [DWW-1:0] dwell_m1;
  assign dwell_m1 = (dwell == '0) ? '0 : (dwell - DWW'(1));

  // Next frequency evaluated at the last dwell cycle
  logic [APR-1:0] nxt_phi;
  logic           nxt_dir;
  logic           nxt_end;

  always_comb begin
    nxt_phi = phi_q;
    nxt_dir = dir_q;
    nxt_end = 1'b0;
    if (!dir_q) begin
      case (mode_q)
        2'd1: nxt_phi = over ? fstart_q : sum_x[APR-1:0];
        2'd2: begin
          if (over) begin
            // Turn around without repeating the peak; hold if that would
            // undershoot the lower bound.
            nxt_dir = 1'b1;
            if (!under) nxt_phi = diff_x[APR-1:0];
          end else begin
            nxt_phi = sum_x[APR-1:0];
          end
        end
        default: begin
          if (over || (fstep_q == '0)) nxt_end = 1'b1;
          else                         nxt_phi = sum_x[APR-1:0];
        end
      endcase
    end else begin
      if (under) begin
        nxt_dir = 1'b0;
        if (!over) nxt_phi = sum_x[APR-1:0];
      end else begin
        nxt_phi = diff_x[APR-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    phi_d    = phi_q;
    step_d   = 1'b0;
    dir_d    = dir_q;
    dcnt_d   = dcnt_q;
    dlen_d   = dlen_q;
    mode_d   = mode_q;
    fstart_d = fstart_q;
    fstop_d  = fstop_q;
    fstep_d  = fstep_q;
    drain_d  = drain_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          mode_d   = mode;
          fstart_d = f_start;
          fstop_d  = f_stop;
          fstep_d  = f_step;
          dlen_d   = dwell_m1;
          dcnt_d   = dwell_m1;
          phi_d    = f_start;
          step_d   = 1'b1;
          dir_d    = 1'b0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_DRAIN;
          drain_d = DRW'(NCO_LAT - 1);
        end else if (dcnt_q != '0) begin
          dcnt_d = dcnt_q - DWW'(1);
        end else begin
          dcnt_d = dlen_q;
          if (nxt_end) begin
            state_d = S_DRAIN;
            drain_d = DRW'(NCO_LAT - 1);
          end else begin
            phi_d  = nxt_phi;
            dir_d  = nxt_dir;
            step_d = (nxt_phi != phi_q);
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_DONE;
        else               drain_d = drain_q - DRW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Marker delay line advances only while the NCO is clocked.
  generate
    if (NCO_LAT == 1) begin : g_sr_single
      assign sr_shift = step_q;
    end else begin : g_sr_multi
      assign sr_shift = {sr_q[NCO_LAT-2:0], step_q};
    end
  endgenerate

  assign sr_d = nco_clken ? sr_shift : sr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      phi_q    <= '0;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      dcnt_q   <= '0;
      dlen_q   <= '0;
      mode_q   <= '0;
      fstart_q <= '0;
      fstop_q  <= '0;
      fstep_q  <= '0;
      drain_q  <= '0;
      sr_q     <= '0;
    end else begin
      state_q  <= state_d;
      phi_q    <= phi_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      dcnt_q   <= dcnt_d;
      dlen_q   <= dlen_d;
      mode_q   <= mode_d;
      fstart_q <= fstart_d;
      fstop_q  <= fstop_d;
      fstep_q  <= fstep_d;
      drain_q  <= drain_d;
      sr_q     <= sr_d;
    end
  end

  assign phi_inc_o    = phi_q;
  assign nco_clken    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign step_o       = step_q;
  assign step_aligned = sr_q[NCO_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_nco_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nco_sweep_ctrl
// Purpose  : Directed self-checking bench for nco_sweep_ctrl with
//            hand-computed expected sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nco_sweep_ctrl;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [1:0]  mode;
  logic [31:0] f_start;
  logic [31:0] f_stop;
  logic [31:0] f_step;
  logic [15:0] dwell;
  logic [31:0] phi_inc_o;
  logic        nco_clken;
  logic        busy;
  logic        done;
  logic        step_o;
  logic        step_aligned;

  int n_tests = 0;
  int n_fail  = 0;

  nco_sweep_ctrl #(.APR(32), .DWW(16), .NCO_LAT(7)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .mode         (mode),
    .f_start      (f_start),
    .f_stop       (f_stop),
    .f_step       (f_step),
    .dwell        (dwell),
    .phi_inc_o    (phi_inc_o),
    .nco_clken    (nco_clken),
    .busy         (busy),
    .done         (done),
    .step_o       (step_o),
    .step_aligned (step_aligned)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] m, input logic [31:0] fs, input logic [31:0] fe,
                     input logic [31:0] st, input logic [15:0] dw);
    mode = m; f_start = fs; f_stop = fe; f_step = st; dwell = dw;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int seq2 [9] = '{10, 20, 30, 20, 10, 20, 30, 20, 10};
  int seq4 [3] = '{5, 12, 19};
  int nsteps;

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg(2'd0, 32'd0, 32'd0, 32'd0, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_phi",   phi_inc_o,    32'd0);
    check("rst_clken", nco_clken,    32'd0);
    check("rst_busy",  busy,         32'd0);
    check("rst_done",  done,         32'd0);
    check("rst_step",  step_o,       32'd0);
    check("rst_algn",  step_aligned, 32'd0);
    reset_n = 1'b1;
    tick();

    // Single up-ramp, dwell 3
    cfg(2'd0, 32'd100, 32'd400, 32'd100, 16'd3);
    go();
    nsteps = 0;
    for (int c = 1; c <= 21; c++) begin
      check("t1_phi",   phi_inc_o, (c <= 12) ? 32'(100 * ((c - 1) / 3 + 1)) : 32'd400);
      check("t1_step",  step_o,    32'((c <= 12) && ((c - 1) % 3 == 0)));
      check("t1_clken", nco_clken, 32'(c <= 19));
      check("t1_busy",  busy,      32'(c <= 20));
      check("t1_done",  done,      32'(c == 20));
      check("t1_algn",  step_aligned, 32'((c == 8) || (c == 11) || (c == 14) || (c == 17)));
      nsteps += int'(step_o);
      tick();
    end
    check("t1_nsteps", 32'(nsteps), 32'd4);

    // Triangle, dwell 1, abort after 9 cycles (second abort in DRAIN ignored)
    cfg(2'd2, 32'd10, 32'd30, 32'd10, 16'd1);
    go();
    for (int c = 1; c <= 9; c++) begin
      check("t2_phi",   phi_inc_o, 32'(seq2[c-1]));
      check("t2_step",  step_o,    32'd1);
      check("t2_clken", nco_clken, 32'd1);
      if (c == 9) abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    for (int c = 10; c <= 18; c++) begin
      check("t2_dphi",   phi_inc_o, 32'd10);
      check("t2_dstep",  step_o,    32'd0);
      check("t2_dclken", nco_clken, 32'(c <= 16));
      check("t2_ddone",  done,      32'(c == 17));
      check("t2_dbusy",  busy,      32'(c <= 17));
      if (c == 12) abort = 1'b1;
      tick();
      abort = 1'b0;
    end

    // Top-of-range ramp: must not wrap to 0
    cfg(2'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 16'd1);
    go();
    for (int c = 1; c <= 10; c++) begin
      check("t3_phi",   phi_inc_o, (c == 1) ? 32'hFFFF_FF00 : 32'hFFFF_FF80);
      check("t3_step",  step_o,    32'(c <= 2));
      check("t3_clken", nco_clken, 32'(c <= 9));
      check("t3_done",  done,      32'(c == 10));
      tick();
    end

    // Sawtooth, dwell 0, marker alignment incl. delivery during DRAIN
    cfg(2'd1, 32'd5, 32'd20, 32'd7, 16'd0);
    go();
    for (int c = 1; c <= 12; c++) begin
      check("t4_phi",  phi_inc_o,    32'(seq4[(c - 1) % 3]));
      check("t4_step", step_o,       32'd1);
      check("t4_algn", step_aligned, 32'(c >= 8));
      if (c == 12) abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    for (int c = 13; c <= 20; c++) begin
      check("t4_dphi",  phi_inc_o,    32'd19);
      check("t4_dalgn", step_aligned, 32'(c <= 19));
      check("t4_ddone", done,         32'(c == 20));
      tick();
    end

    // start+abort together in IDLE: no response
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("t5_busy",  busy,      32'd0);
    check("t5_clken", nco_clken, 32'd0);
    check("t5_step",  step_o,    32'd0);
    tick();
    check("t5_busy2", busy,      32'd0);

    // start while busy is ignored
    cfg(2'd0, 32'd10, 32'd20, 32'd10, 16'd2);
    go();
    for (int c = 1; c <= 13; c++) begin
      check("t5_phi",   phi_inc_o, (c <= 2) ? 32'd10 : 32'd20);
      check("t5_stp",   step_o,    32'((c == 1) || (c == 3)));
      check("t5_clk",   nco_clken, 32'(c <= 11));
      check("t5_done",  done,      32'(c == 12));
      check("t5_bsy",   busy,      32'(c <= 12));
      if (c == 2) begin
        start = 1'b1;
        f_start = 32'd999;
      end
      tick();
      start = 1'b0;
    end

    // Asynchronous reset mid-sweep, then a clean sweep
    cfg(2'd1, 32'd100, 32'd200, 32'd10, 16'd1);
    go();
    repeat (3) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_phi",   phi_inc_o,    32'd0);
    check("t6_clken", nco_clken,    32'd0);
    check("t6_busy",  busy,         32'd0);
    check("t6_done",  done,         32'd0);
    check("t6_step",  step_o,       32'd0);
    check("t6_algn",  step_aligned, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    cfg(2'd0, 32'd50, 32'd70, 32'd10, 16'd2);
    go();
    for (int c = 1; c <= 15; c++) begin
      check("t6_rphi",   phi_inc_o, (c <= 2) ? 32'd50 : ((c <= 4) ? 32'd60 : 32'd70));
      check("t6_rstep",  step_o,    32'((c == 1) || (c == 3) || (c == 5)));
      check("t6_rclken", nco_clken, 32'(c <= 13));
      check("t6_rdone",  done,      32'(c == 14));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
